// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 2-bit multi-cycle ALU command sequencer.
// Command entries are packed {a, b, op}, 6 bits wide.
package alu_seq_pkg;

  localparam int OPND_W = 2;
  localparam int RES_W  = 3;
  localparam int OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [OP_W-1:0]   op;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH x 6-bit {a, b, op}, registered pointers, head read combinationally.
// Latency: a push is visible at head/count one cycle later, no empty bypass.
// Backpressure: full refuses pushes; pop on empty is ignored.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_t                   push_cmd,
  input  logic                   pop,
  output cmd_t                   head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are power-of-2 wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_cmd;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues queued {A,B,Op} commands to the multi-cycle ALU one at a time; optional ALU_TIMEOUT_EN.
// Latency: push cycle 0 -> alu_start cycle 2 -> res_valid one cycle after alu_done.
// Backpressure: no issue while a result waits on res_ready; FIFO accepts until full.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OPND_W-1:0]      cmd_a,
  input  logic [OPND_W-1:0]      cmd_b,
  input  logic [OP_W-1:0]        cmd_op,
  output logic                   alu_start,
  output logic [OPND_W-1:0]      alu_a,
  output logic [OPND_W-1:0]      alu_b,
  output logic [OP_W-1:0]        alu_op,
  input  logic [RES_W-1:0]       alu_y,
  input  logic                   alu_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RES_W-1:0]       res_y,
  output logic [OP_W-1:0]        res_op,
  output logic                   res_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_cmd_sequencer: DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("alu_cmd_sequencer: TIMEOUT must be at least 1");
  end

  seq_state_t state;
  seq_state_t state_nxt;
  cmd_t       head;
  cmd_t       push_cmd;
  logic       push;
  logic       pop;
  logic       capture;
  logic       tmo_hit;
  logic       fifo_full;
  logic       fifo_empty;

  assign push_cmd  = '{a: cmd_a, b: cmd_b, op: cmd_op};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign capture   = (state == WAIT) && alu_done;
  assign pop       = capture || tmo_hit;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Operands come straight from the head; it only moves at capture, so they hold through WAIT.
  assign alu_a     = head.a;
  assign alu_b     = head.b;
  assign alu_op    = head.op;
  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_start = 1'b0;
    case (state)
      IDLE:  if (!fifo_empty) state_nxt = ISSUE;
      ISSUE: begin
        alu_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (pop) state_nxt = RESP;
      RESP: begin
        // A push landing this cycle is at the head by the time ISSUE runs.
        if (res_ready) state_nxt = (!fifo_empty || push) ? ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_y  <= '0;
      res_op <= '0;
    end else if (capture) begin
      res_y  <= alu_y;
      res_op <= head.op;
    end else if (tmo_hit) begin
      res_y  <= '0;
      res_op <= head.op;
    end
  end

`ifdef ALU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // Counter holds the number of WAIT cycles already elapsed; fires on the TIMEOUT-th one.
  assign tmo_hit = (state == WAIT) && !alu_done && (tmo_cnt == TMO_LAST);
  assign res_err = err_q;

  always_ff @(posedge clk) begin
    if (reset)                tmo_cnt <= '0;
    else if (state == ISSUE)  tmo_cnt <= '0;
    else if (state == WAIT)   tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)                          err_q <= 1'b0;
    else if (tmo_hit)                   err_q <= 1'b1;
    else if (capture)                   err_q <= 1'b0;
    else if (state == RESP && res_ready) err_q <= 1'b0;
  end
`else
  assign tmo_hit = 1'b0;
  assign res_err = 1'b0;
`endif

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream command stage for the multi-cycle 2-bit ALU (MultiCycleALU). It buffers {A, B, Op} commands in a small FIFO and issues them one at a time, using a one-cycle start pulse. It holds the operands stable until the ALU's done, captures Y, and presents it downstream on a valid/ready result port. Exactly one command is outstanding at the ALU at any time.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, ≥2
TIMEOUT, 15, cycles in WAIT before error (used only with ALU_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  upstream command valid
cmd_ready  out  1  FIFO not full
cmd_a  in  2  operand A
cmd_b  in  2  operand B
cmd_op  in  2  00 add, 01 sub, 10 and, 11 or
alu_start  out  1  start pulse to ALU
alu_a  out  2  operand A to ALU (FIFO head)
alu_b  out  2  operand B to ALU
alu_op  out  2  opcode to ALU
alu_y  in  3  ALU result
alu_done  in  1  ALU done, high one cycle
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_y  out  3  captured result
res_op  out  2  opcode echo of the captured result
res_err  out  1  timeout error flag (constant 0 without ALU_TIMEOUT_EN)
busy  out  1  state != IDLE or FIFO non-empty
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (synchronous, active-high), applied mid-operation or otherwise:
  - state=IDLE, FIFO empty, count=0.
  - res_valid=0, res_y=0, res_op=0, res_err=0, alu_start=0, busy=0.
  - The ALU shares the reset. An alu_done arriving after reset is ignored.
- Push: occurs when cmd_valid && cmd_ready. cmd_ready = (count != DEPTH). A push is visible in count on the next cycle. There is no empty-bypass.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Pop: occurs only at result capture (WAIT && alu_done). Push and pop in the same cycle leave count unchanged.
- alu_a, alu_b and alu_op are driven from the FIFO head. They stay stable from ISSUE through the capture cycle.
- FSM:
  - IDLE: goes to ISSUE when count != 0.
  - ISSUE: lasts exactly 1 cycle. alu_start=1 (combinational, ISSUE only). Goes to WAIT.
  - WAIT: on alu_done, register res_y<=alu_y and res_op<=head op, pop the FIFO, and go to RESP. alu_done seen in any other state is ignored.
  - RESP: res_valid=1, and res_y/res_op are held stable. On res_ready, go to ISSUE if count(after any pop/push) != 0, else IDLE.
- Latency: push in cycle 0 → ISSUE in cycle 2 → ALU done in cycle 5 → res_valid in cycle 6. Back-to-back commands with res_ready tied high complete every 5 cycles.
- Result width: res_y is 3 bits exactly as returned by the ALU. Subtraction wraps mod 8 and is not modified here.
- Backpressure: no new command is issued while res_valid=1 and res_ready=0. The FIFO keeps accepting until full.

Optional Feature:
ALU_TIMEOUT_EN
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT without alu_done: pop the head, res_y=0, res_err=1, and go to RESP.
  - res_err clears when the result is accepted.
- Undefined: no counter; WAIT waits indefinitely; res_err is tied to 0.

Decomposition:
- Package alu_seq_pkg:
  - seq_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - Opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR.
  - Width constants OPND_W=2, RES_W=3.
- Sub-module alu_cmd_fifo:
  - DEPTH-entry synchronous FIFO, {a, b, op} 6-bit entries.
  - Ports: push, pop, head, count, full, empty.
- The FSM and result register stay in the top module.

Test Plan:
- Single add A=3,B=2,Op=00, res_ready=1 → alu_start pulse in cycle 2; res_valid in cycle 6 with res_y=5, res_op=00.
- Sub A=1,B=2,Op=01 → res_y=7 (wrap). Then and A=3,B=1 → res_y=1. Then or A=2,B=1 → res_y=3. All results appear in order.
- Push DEPTH+1 commands back-to-back with res_ready=0 → cmd_ready=0 once count=4 and the extra push is refused. Release res_ready → 4 results in FIFO order, count returns to 0.
- Hold res_ready=0 for 10 cycles in RESP → res_y stable and no alu_start pulses. Accept → next ISSUE follows the next cycle.
- Assert reset during WAIT with 3 commands queued → next cycle state=IDLE, count=0, res_valid=0. A late alu_done produces no result.
- ALU_TIMEOUT_EN, alu_done forced 0 → after 15 WAIT cycles res_valid=1, res_err=1, res_y=0, count decremented by 1.
